uart_rx_ctrl: RTL and testbench

//  Single-clock 8N1 UART receive controller. Synchronises the raw RX pin and

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_baud_tick.sv | 30 +++
 rtl/uart_rx_ctrl.sv | 173 +++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding, data width and
// the clocks-per-oversample-tick divider calculation.
package uart_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } uart_state_e;

  // Truncating divide; a result below 1 is a parameter error and is clamped to 1.
  function automatic int calc_div(input longint clk_hz, input longint baud,
                                  input longint oversample);
    longint div;
    div = clk_hz / (baud * oversample);
    return (div < 1) ? 1 : int'(div);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick generator: one-cycle o_tick every DIV clocks.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_tick
);

  localparam int DIV   = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    o_tick = (cnt_q == CNT_LAST);
    cnt_d  = o_tick ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// 8N1 UART receiver: pin synchroniser, start/data/stop sequencing on the
// oversample tick, and a valid/ack holding register with overrun tracking.
//
// state        | meaning
// IDLE         | line idle, waiting for rx_s low
// START        | confirming start bit at its midpoint
// DATA         | sampling 8 data bits LSB first, one per OVERSAMPLE ticks
// STOP         | sampling stop bit; high loads byte, low flags frame error
// WAIT_IDLE    | after framing error, wait for line to return high
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rx,
  input  logic              i_rx_ack,
  output logic [DATA_W-1:0] o_rx_byte,
  output logic              o_rx_valid,
  output logic              o_frame_err,
  output logic              o_overrun,
  output logic              o_busy
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  logic tick;
  logic rx_s;
  logic load;

  logic              sync1_q, sync2_q;
  uart_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BIT_W-1:0]  bit_idx_q, bit_idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] byte_q, byte_d;
  logic              valid_q, valid_d;
  logic              overrun_q, overrun_d;
  logic              frame_err_q, frame_err_d;

  uart_baud_tick #(
    .CLK_HZ    (CLK_HZ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_baud_tick (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .o_tick(tick)
  );

  // Synchroniser resets to the idle line level so reset release cannot look like a start bit.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= i_rx;
      sync2_q <= sync1_q;
    end
  end

  assign rx_s = sync2_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    byte_d      = byte_q;
    valid_d     = valid_q;
    overrun_d   = overrun_q;
    frame_err_d = 1'b0;
    load        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (tick && !rx_s) begin
          state_d = ST_START;
          cnt_d   = '0;
        end
      end
      ST_START: begin
        if (tick) begin
          if (cnt_q == CNT_HALF) begin
            cnt_d     = '0;
            bit_idx_d = '0;
            state_d   = rx_s ? ST_IDLE : ST_DATA;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (cnt_q == CNT_LAST) begin
            shift_d   = {rx_s, shift_q[DATA_W-1:1]};
            cnt_d     = '0;
            bit_idx_d = bit_idx_q + BIT_W'(1);
            if (bit_idx_q == BIT_LAST) state_d = ST_STOP;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (rx_s) begin
              load    = 1'b1;
              state_d = ST_IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = ST_WAIT_IDLE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_WAIT_IDLE: begin
        if (rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A simultaneous ack consumes the old byte, so the overwrite is not an overrun.
    if (load) begin
      byte_d    = shift_q;
      valid_d   = 1'b1;
      overrun_d = valid_q & ~i_rx_ack;
    end else if (i_rx_ack && valid_q) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      byte_q      <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      byte_q      <= byte_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign o_rx_byte   = byte_q;
  assign o_rx_valid  = valid_q;
  assign o_overrun   = overrun_q;
  assign o_frame_err = frame_err_q;
  assign o_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl at 16 clocks per bit (DIV=1).
module tb_uart_rx_ctrl;

  logic       i_clk;
  logic       i_rst;
  logic       i_rx;
  logic       i_rx_ack;
  logic [7:0] o_rx_byte;
  logic       o_rx_valid;
  logic       o_frame_err;
  logic       o_overrun;
  logic       o_busy;

  int n_pass  = 0;
  int n_total = 0;
  int fe_cnt  = 0;

  uart_rx_ctrl #(
    .CLK_HZ    (16_000_000),
    .BAUD      (1_000_000),
    .OVERSAMPLE(16)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_rx       (i_rx),
    .i_rx_ack   (i_rx_ack),
    .o_rx_byte  (o_rx_byte),
    .o_rx_valid (o_rx_valid),
    .o_frame_err(o_frame_err),
    .o_overrun  (o_overrun),
    .o_busy     (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Counts cycles with frame_err high, so a one-cycle pulse adds exactly 1.
  always @(negedge i_clk) if (o_frame_err === 1'b1) fe_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic drive_bits(input logic v, input int n);
    i_rx = v;
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic ack_pulse();
    i_rx_ack = 1'b1;
    @(posedge i_clk);
    #1;
    i_rx_ack = 1'b0;
  endtask

  // Drives start + 8 data + stop, 16 clocks each. ack is high only during
  // cycle ack_cyc; rise returns the edge number (1-based from the start bit)
  // at which o_rx_valid went high, or -1.
  task automatic send_frame(input logic [7:0] b, input logic stop,
                            input int ack_cyc, output int rise);
    logic [9:0] fr;
    logic       pv;
    fr   = {stop, b, 1'b0};
    rise = -1;
    for (int c = 0; c < 160; c++) begin
      i_rx     = fr[c/16];
      i_rx_ack = (c == ack_cyc);
      pv       = o_rx_valid;
      @(posedge i_clk);
      #1;
      if (!pv && o_rx_valid && rise < 0) rise = c + 1;
    end
    i_rx_ack = 1'b0;
  endtask

  initial begin
    int rise;
    int fe0;

    i_rst    = 1'b1;
    i_rx     = 1'b1;
    i_rx_ack = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_valid",   o_rx_valid,  1'b0);
    check("rst_byte",    o_rx_byte,   8'h00);
    check("rst_ferr",    o_frame_err, 1'b0);
    check("rst_overrun", o_overrun,   1'b0);
    check("rst_busy",    o_busy,      1'b0);
    i_rst = 1'b0;
    drive_bits(1'b1, 8);

    // 1: basic byte and latency (start edge to valid = 8 + 144 + 3 = 155 clocks)
    fe0 = fe_cnt;
    send_frame(8'h55, 1'b1, -1, rise);
    check("t1_byte",    o_rx_byte,  8'h55);
    check("t1_valid",   o_rx_valid, 1'b1);
    check("t1_latency", (rise >= 153 && rise <= 157), 1'b1);
    check("t1_overrun", o_overrun,  1'b0);
    check("t1_ferr",    fe_cnt - fe0, 0);
    ack_pulse();
    check("t1_ack_valid", o_rx_valid, 1'b0);
    drive_bits(1'b1, 4);

    // 2: 4-clock glitch is rejected at the start-bit midpoint
    fe0 = fe_cnt;
    drive_bits(1'b0, 4);
    check("t2_busy_in", o_busy, 1'b1);
    drive_bits(1'b1, 20);
    check("t2_busy_out", o_busy,     1'b0);
    check("t2_valid",    o_rx_valid, 1'b0);
    check("t2_ferr",     fe_cnt - fe0, 0);

    // 3: framing error, break held low, then recovery
    fe0 = fe_cnt;
    send_frame(8'hA3, 1'b0, -1, rise);
    drive_bits(1'b0, 32);
    check("t3_ferr_pulse", fe_cnt - fe0, 1);
    check("t3_valid",      o_rx_valid,   1'b0);
    check("t3_wait_busy",  o_busy,       1'b1);
    drive_bits(1'b1, 4);
    check("t3_idle_busy",  o_busy,       1'b0);
    send_frame(8'h3C, 1'b1, -1, rise);
    check("t3_next_byte",  o_rx_byte,    8'h3C);
    check("t3_next_valid", o_rx_valid,   1'b1);
    check("t3_ferr_once",  fe_cnt - fe0, 1);
    ack_pulse();
    drive_bits(1'b1, 4);

    // 4: overrun when a second byte lands unacked
    send_frame(8'h12, 1'b1, -1, rise);
    check("t4_first_byte", o_rx_byte, 8'h12);
    check("t4_first_ovr",  o_overrun, 1'b0);
    send_frame(8'h34, 1'b1, -1, rise);
    check("t4_byte",    o_rx_byte,  8'h34);
    check("t4_valid",   o_rx_valid, 1'b1);
    check("t4_overrun", o_overrun,  1'b1);
    ack_pulse();
    check("t4_ack_valid",   o_rx_valid, 1'b0);
    check("t4_ack_overrun", o_overrun,  1'b0);
    drive_bits(1'b1, 4);

    // 5: ack on the exact load cycle (edge 155 -> driven during cycle 154)
    send_frame(8'h12, 1'b1, -1, rise);
    check("t5_first_valid", o_rx_valid, 1'b1);
    send_frame(8'h34, 1'b1, 154, rise);
    check("t5_byte",    o_rx_byte,  8'h34);
    check("t5_valid",   o_rx_valid, 1'b1);
    check("t5_overrun", o_overrun,  1'b0);

    // 6: asynchronous reset during DATA bit 3 of 0xFF, with 0x34 still held
    drive_bits(1'b0, 16);
    drive_bits(1'b1, 56);
    check("t6_busy_pre", o_busy, 1'b1);
    #2;
    i_rst = 1'b1;
    #1;
    check("t6_rst_valid",   o_rx_valid,  1'b0);
    check("t6_rst_byte",    o_rx_byte,   8'h00);
    check("t6_rst_overrun", o_overrun,   1'b0);
    check("t6_rst_ferr",    o_frame_err, 1'b0);
    check("t6_rst_busy",    o_busy,      1'b0);
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    drive_bits(1'b1, 40);
    fe0 = fe_cnt;
    send_frame(8'hC3, 1'b1, -1, rise);
    check("t6_byte",    o_rx_byte,  8'hC3);
    check("t6_valid",   o_rx_valid, 1'b1);
    check("t6_overrun", o_overrun,  1'b0);
    check("t6_ferr",    fe_cnt - fe0, 0);
    drive_bits(1'b1, 4);
    check("t6_busy_end", o_busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
